// File: rtl/le_strobe_seq_if.sv
// Signal bundle between a latch-enable sequencer and its requester.
// The requester drives the controls; the sequencer drives the enables and status.
interface le_strobe_seq_if #(
  parameter int AW = 3,
  parameter int HW = 8
);
  localparam int N = 1 << AW;

  logic          en;
  logic          mode;
  logic          start;
  logic [AW-1:0] Addr;
  logic [HW-1:0] hold;
  logic [N-1:0]  LE;
  logic [AW-1:0] cur_addr;
  logic          busy;
  logic          done;

  modport master (
    output en, mode, start, Addr, hold,
    input  LE, cur_addr, busy, done
  );

  modport slave (
    input  en, mode, start, Addr, hold,
    output LE, cur_addr, busy, done
  );
endinterface

// File: rtl/le_strobe_seq.sv
// Registered one-hot latch-enable generator: single strobe or round-robin scan
// with a one-cycle all-zero guard between scan slots.
module le_strobe_seq #(
  parameter int AW = 3,
  parameter int HW = 8
) (
  input logic           clk,
  input logic           rst_n,
  le_strobe_seq_if.slave bus
);
  localparam int N = 1 << AW;

  typedef enum logic [1:0] {IDLE, STROBE, GUARD} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] w_q, w_d;
  logic          scan_q, scan_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [N-1:0]  le_q, le_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [HW-1:0] hold_w;
  logic [AW-1:0] addr_nx;

  function automatic logic [N-1:0] onehot(input logic [AW-1:0] a);
    logic [N-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // A zero hold still gives a one-cycle strobe.
  assign hold_w  = (bus.hold == '0) ? HW'(1) : bus.hold;
  assign addr_nx = addr_q + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      scan_q  <= 1'b0;
      addr_q  <= '0;
      le_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      scan_q  <= scan_d;
      addr_q  <= addr_d;
      le_q    <= le_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // cnt_q holds the strobe cycles still remaining after the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    scan_d  = scan_q;
    addr_d  = addr_q;
    le_d    = le_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      le_d    = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          le_d   = '0;
          busy_d = 1'b0;
          if (bus.start) begin
            state_d = STROBE;
            addr_d  = bus.Addr;
            w_d     = hold_w;
            cnt_d   = hold_w - HW'(1);
            scan_d  = bus.mode;
            le_d    = onehot(bus.Addr);
            busy_d  = 1'b1;
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            le_d = '0;
            if (scan_q) begin
              state_d = GUARD;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - HW'(1);
          end
        end
        GUARD: begin
          // The live mode input decides whether the sweep continues.
          if (bus.mode) begin
            state_d = STROBE;
            addr_d  = addr_nx;
            le_d    = onehot(addr_nx);
            cnt_d   = w_q - HW'(1);
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          le_d    = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.LE       = le_q;
  assign bus.cur_addr = addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_le_strobe_seq.sv
// Directed and randomised checks of le_strobe_seq against a trace-level model.
module tb_le_strobe_seq;
  localparam int AW = 3;
  localparam int HW = 8;
  localparam int N  = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   last_ca = 0;

  typedef struct packed {
    logic [N-1:0]  le;
    logic          busy;
    logic          done;
    logic [AW-1:0] ca;
    logic          md;
  } ent_t;

  ent_t q[$];

  le_strobe_seq_if #(.AW(AW), .HW(HW)) bus ();

  le_strobe_seq #(.AW(AW), .HW(HW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inv();
    logic [N-1:0] le;
    logic [N-1:0] sel;
    le  = bus.LE;
    sel = '0;
    sel[bus.cur_addr] = 1'b1;
    chk("onehot", 32'($countones(le) <= 1), 32'd1);
    chk("le_is_cur_or_zero", 32'((le == '0) || (le == sel)), 32'd1);
  endtask

  // Expected per-cycle trace of one operation, derived from strobe/guard/done rules.
  task automatic build(input bit scan, input int a, input int h, input int slots);
    ent_t e;
    int w;
    int ns;
    int ad;
    w  = (h == 0) ? 1 : h;
    ns = scan ? slots : 1;
    ad = a;
    q.delete();
    for (int s = 0; s < ns; s++) begin
      ad = (a + s) % N;
      for (int c = 0; c < w; c++) begin
        e.le   = '0;
        e.le[ad] = 1'b1;
        e.busy = 1'b1;
        e.done = 1'b0;
        e.ca   = AW'(ad);
        e.md   = (s < ns - 1);
        q.push_back(e);
      end
      if (scan) begin
        e.le   = '0;
        e.busy = 1'b1;
        e.done = 1'b0;
        e.ca   = AW'(ad);
        e.md   = (s < ns - 1);
        q.push_back(e);
      end
    end
    e.le   = '0;
    e.busy = 1'b0;
    e.done = 1'b1;
    e.ca   = AW'(ad);
    e.md   = 1'b0;
    q.push_back(e);
    last_ca = ad;
  endtask

  task automatic run_op(input bit scan, input int a, input int h, input int slots, input bit noise);
    ent_t e;
    int   k;
    build(scan, a, h, slots);
    k = 0;
    bus.en    = 1'b1;
    bus.start = 1'b1;
    bus.mode  = scan;
    bus.Addr  = AW'(a);
    bus.hold  = HW'(h);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      chk($sformatf("op_le[%0d]", k), 32'(bus.LE), 32'(e.le));
      chk($sformatf("op_busy[%0d]", k), 32'(bus.busy), 32'(e.busy));
      chk($sformatf("op_done[%0d]", k), 32'(bus.done), 32'(e.done));
      chk($sformatf("op_cur[%0d]", k), 32'(bus.cur_addr), 32'(e.ca));
      chk_inv();
      bus.start = (noise && e.busy) ? 1'b1 : 1'b0;
      if (noise) begin
        bus.Addr = AW'($urandom);
        bus.hold = HW'($urandom);
      end
      bus.mode = scan ? e.md : 1'($urandom);
      k++;
    end
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_le", 32'(bus.LE), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_done", 32'(bus.done), 32'd0);
      chk("idle_cur", 32'(bus.cur_addr), 32'(last_ca));
    end
  endtask

  initial begin
    bus.en    = 1'b0;
    bus.mode  = 1'b0;
    bus.start = 1'b0;
    bus.Addr  = '0;
    bus.hold  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_le", 32'(bus.LE), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_cur", 32'(bus.cur_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.en = 1'b1;

    // Asynchronous reset in the middle of a strobe
    bus.start = 1'b1;
    bus.Addr  = 3'd5;
    bus.hold  = 8'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("pre_rst_le", 32'(bus.LE), 32'h20);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_le", 32'(bus.LE), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_cur", 32'(bus.cur_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_ca = 0;
    idle(1);

    // Single strobes, hold=3 then hold=0
    run_op(1'b0, 5, 3, 1, 1'b0);
    idle(1);
    run_op(1'b0, 5, 0, 1, 1'b0);
    idle(1);

    // Scan from 6 with wrap, mode dropped during the last slot's strobe
    run_op(1'b1, 6, 2, 4, 1'b0);
    idle(1);

    // Abort in the second cycle of a hold=4 strobe
    bus.en    = 1'b1;
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.Addr  = 3'd2;
    bus.hold  = 8'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("abort_le1", 32'(bus.LE), 32'h04);
    @(posedge clk); #1;
    chk("abort_le2", 32'(bus.LE), 32'h04);
    bus.en = 1'b0;
    @(posedge clk); #1;
    chk("abort_le", 32'(bus.LE), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_cur", 32'(bus.cur_addr), 32'd2);
    bus.en = 1'b1;
    last_ca = 2;
    idle(4);

    // start held high and Addr/hold churn during a single strobe
    run_op(1'b0, 1, 3, 1, 1'b1);
    idle(1);

    // start with en low is dropped
    bus.en    = 1'b0;
    bus.start = 1'b1;
    bus.Addr  = 3'd3;
    repeat (3) begin
      @(posedge clk); #1;
      chk("en0_le", 32'(bus.LE), 32'd0);
      chk("en0_busy", 32'(bus.busy), 32'd0);
      chk("en0_cur", 32'(bus.cur_addr), 32'(last_ca));
    end
    bus.start = 1'b0;
    bus.en    = 1'b1;
    idle(1);

    // Randomised operations, including back-to-back starts
    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom), int'($urandom % N), int'($urandom % 5),
             1 + int'($urandom % 4), 1'($urandom));
      idle(int'($urandom % 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/le_strobe_seq.md
# le_strobe_seq

Parametrised, registered latch-enable generator for the address-decode path. It decodes an AW-bit address into a one-hot latch-enable bus of 2**AW lines. Each strobe is held for a programmable number of cycles. In single mode it strobes one address per request; in scan mode it steps round-robin across all lines, with a one-cycle all-zero guard between slots. It drives the latch-enable bus of the downstream register/display banks, replacing the purely combinational 3-to-8 decode stage.

## Interface
- AW, default 3: address width; output count N = 2**AW.
- HW, default 8: width of the hold-count input.
- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable. Low forces LE to zero and aborts any operation.
- mode  in  1  0 = single strobe, 1 = round-robin scan; sampled with start.
- start  in  1  request pulse; honoured only in IDLE with en=1.
- Addr  in  AW  single mode: target line. Scan mode: first line.
- hold  in  HW  strobe width in cycles, sampled at start; 0 is treated as 1.
- LE  out  N  registered one-hot latch enables; all-zero when idle or in a guard cycle.
- cur_addr  out  AW  address of the current or most recent strobe.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- Reset values: LE=0, cur_addr=0, busy=0, done=0, state IDLE, hold counter 0.
- States: IDLE, STROBE, GUARD.
- IDLE → STROBE when start=1 and en=1.
  - On this transition: latch Addr into cur_addr, latch W = max(hold,1), latch mode into the scan flag.
  - start=1 while en=0 is dropped, not queued.
- STROBE:
  - LE = 1 << cur_addr. The counter runs W cycles.
  - Single mode: after W cycles, → IDLE with done=1 for one cycle.
  - Scan mode: after W cycles, → GUARD.
- GUARD (scan only):
  - LE=0 for exactly one cycle.
  - If the live mode input = 1: cur_addr increments modulo N (N-1 wraps to 0), → STROBE.
  - If mode = 0: → IDLE, done=1. Scan stops only at a slot boundary; the current slot always completes.
- en=0 in any state: the next cycle has LE=0, busy=0, state IDLE, done=0 (abort, not a completion). cur_addr keeps its value.
- start while busy is ignored. hold and Addr changes during an operation have no effect.
- No more than one bit of LE is ever high. Two lines are never high in the same cycle, including across slot changes.
- Asynchronous reset mid-operation immediately returns all outputs to their reset values.

## Timing
- start sampled at edge T, accepted → LE valid and busy=1 from edge T+1.
- Single strobe: LE high for cycles T+1 .. T+W.
  - done=1 and busy=0 in cycle T+W+1.
  - A new start is accepted at the edge ending cycle T+W+1.
- Scan slot period = W+1 cycles (W strobe + 1 guard). A full sweep is N*(W+1) cycles.
- Scan stop: mode sampled during the GUARD cycle; done=1 and busy=0 in the following cycle.
- en drop at edge E: LE=0 from cycle E+1 (one-cycle registered latency, no combinational path en→LE).
- All outputs come directly from flops.

## Test plan
- Reset with rst_n=0 asserted mid-strobe (AW=3): LE=0x00, busy=0, done=0, cur_addr=0 immediately, without waiting for a clock edge.
- Single, Addr=5, hold=3, mode=0: LE=0x20 for exactly 3 cycles starting one cycle after start, then done pulses for 1 cycle and busy falls. Repeat with hold=0: LE=0x20 for 1 cycle.
- Scan, Addr=6, hold=2, mode held 1:
  - LE sequence 0x40,0x40,0x00,0x80,0x80,0x00,0x01,0x01,0x00,0x02 (wrap 7→0 verified).
  - Drop mode during a strobe: the slot finishes, the guard cycle follows, then done=1.
- Abort: en→0 during the second cycle of a hold=4 strobe on Addr=2. LE=0 the next cycle, busy=0, done never pulses, cur_addr stays 2.
- Ignored inputs:
  - start held high throughout a single strobe on Addr=1: only one strobe occurs, and Addr/hold changes mid-strobe do not alter LE or its width.
  - start with en=0: no activity.
- Scoreboard over a randomised run: at most one LE bit high, LE always equals 1<<cur_addr or 0, and the guard cycle is always present between scan slots.
